// File: rtl/sram_master_pkg.sv
// sram_master_pkg: shared FSM state type, default geometry and command
// direction encodings for sram_stream_master and its read-return FIFO.
package sram_master_pkg;

    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_RD_LAT = 1;

    localparam logic CMD_DIR_READ  = 1'b0;
    localparam logic CMD_DIR_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// sram_rd_fifo: synchronous show-ahead FIFO holding SRAM read returns.
// pop_data always presents the oldest entry; count reports occupancy.
// Pushes into a full FIFO and pops from an empty one are ignored.
module sram_rd_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        pop_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign push_ok_s = push && (count_q != CW'(DEPTH));
    assign pop_ok_s  = pop && (count_q != CW'(0));

    // Data storage; contents need no reset because the pointers qualify them.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_q <= count_q + CW'(1);
            end else if (!push_ok_s && pop_ok_s) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == CW'(0));
    assign count    = count_q;

endmodule

// File: rtl/sram_stream_master.sv
// sram_stream_master: turns read/write commands into single-word SRAM
// accesses with streaming read-return and write-data ports.
// Optional write path: define SRAM_STREAM_MASTER_WRITE_EN. Without it,
// write commands finish immediately with a done pulse and no SRAM access.
module sram_stream_master
    import sram_master_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = DEF_RD_LAT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [15:0]           cmd_len,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     sram_address,
    output logic                  sram_chipselect,
    output logic                  sram_write,
    output logic [DATA_W-1:0]     sram_writedata,
    output logic [DATA_W/8-1:0]   sram_byteenable,
    output logic                  sram_clken,
    input  logic [DATA_W-1:0]     sram_readdata
);
    localparam int BE_W = DATA_W / 8;
    localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW   = FCW + 1;

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [15:0]         rem_q;
    logic                cmd_ready_q;
    logic                busy_q;
    logic                done_q;
    logic                wr_ready_q;
    logic [RD_LAT-1:0]   vld_q;
    logic [RD_LAT-1:0]   vld_d;

    logic [CW-1:0]       outstanding_s;
    logic [FCW-1:0]      fifo_count_s;
    logic                fifo_empty_s;
    logic                rd_issue_s;
    logic                wr_issue_s;
    logic                push_s;
    logic                pop_s;
    logic                drained_s;

    // Count reads issued whose data has not yet reached the FIFO.
    always_comb begin
        outstanding_s = CW'(0);
        for (int i = 0; i < RD_LAT; i++) begin
            outstanding_s = outstanding_s + CW'(vld_q[i]);
        end
    end

    // A read only issues if a FIFO slot is guaranteed for its return.
    assign rd_issue_s = (state_q == ST_READ) && (rem_q != 16'd0) &&
                        ((outstanding_s + CW'(fifo_count_s)) < CW'(FIFO_DEPTH));

    assign push_s = vld_q[RD_LAT-1];
    assign pop_s  = !fifo_empty_s && rd_ready;

    // Leaving DRAIN on the cycle of the final pop gives done one cycle later.
    assign drained_s = (outstanding_s == CW'(0)) &&
                       ((fifo_count_s == FCW'(0)) ||
                        ((fifo_count_s == FCW'(1)) && pop_s));

    // Next value of the read-return shift register: one stage per latency cycle.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_issue_s;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    // Read-return valid shift register; cleared by reset to drop in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    sram_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (sram_readdata),
        .pop       (pop_s),
        .pop_data  (rd_data),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Command FSM with registered handshake/status outputs and address/length counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= 16'd0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_addr;
                        rem_q       <= cmd_len;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_len == 16'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else if (cmd_dir == CMD_DIR_READ) begin
                            state_q <= ST_READ;
                        end else begin
`ifdef SRAM_STREAM_MASTER_WRITE_EN
                            state_q    <= ST_WRITE;
                            wr_ready_q <= 1'b1;
`else
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
`endif
                        end
                    end
                end
                ST_READ: begin
                    if (rd_issue_s) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_WRITE: begin
`ifdef SRAM_STREAM_MASTER_WRITE_EN
                    if (wr_issue_s) begin
                        addr_q <= addr_q + ADDR_W'(1);
                        rem_q  <= rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            wr_ready_q <= 1'b0;
                        end
                    end
`else
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
`endif
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    wr_ready_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SRAM_STREAM_MASTER_WRITE_EN
    assign wr_issue_s     = wr_valid && wr_ready_q;
    assign wr_ready       = wr_ready_q;
    assign sram_write     = wr_issue_s;
    assign sram_writedata = wr_issue_s ? wr_data : {DATA_W{1'b0}};
`else
    logic unused_wr_s;
    assign unused_wr_s    = ^{wr_valid, wr_data, wr_ready_q};
    assign wr_issue_s     = 1'b0;
    assign wr_ready       = 1'b0;
    assign sram_write     = 1'b0;
    assign sram_writedata = {DATA_W{1'b0}};
`endif

    assign cmd_ready       = cmd_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign rd_valid        = !fifo_empty_s;
    assign sram_address    = addr_q;
    assign sram_clken      = 1'b1;
    assign sram_chipselect = rd_issue_s || wr_issue_s;
    assign sram_byteenable = sram_chipselect ? {BE_W{1'b1}} : {BE_W{1'b0}};

endmodule
